// File: rtl/bat_register_file.sv
// General-purpose register file (r0=A, r1=B, r7=OUT) with a valid/ready FIFO that captures every OUT update.
// Optional multi-driver bus check enabled by defining BAT_REGFILE_BUS_CHECK_EN.
module bat_register_file #(
  parameter int DATA_W    = 8,
  parameter int NUM_REGS  = 8,
  parameter int OUT_DEPTH = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [NUM_REGS-1:0] REGS_INC,
  input  logic [NUM_REGS-1:0] REGS_RW,
  input  logic [NUM_REGS-1:0] REGS_EN,
  input  logic [DATA_W-1:0]   BUS_IN,
  output logic [DATA_W-1:0]   BUS_OUT,
  output logic                BUS_DRV,
  output logic [DATA_W-1:0]   A_OUT,
  output logic [DATA_W-1:0]   B_OUT,
  output logic [DATA_W-1:0]   OUT_DATA,
  output logic                OUT_VALID,
  input  logic                OUT_READY,
  output logic                OUT_OVF,
  output logic                BUS_CONFLICT
);

  localparam int PTR_W   = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CNT_W   = PTR_W + 1;
  localparam int OUT_IDX = NUM_REGS - 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(OUT_DEPTH);

  logic [DATA_W-1:0]   regs    [NUM_REGS];
  logic [DATA_W-1:0]   reg_nxt [NUM_REGS];
  logic [NUM_REGS-1:0] reg_wr;
  logic [NUM_REGS-1:0] drv;

  assign drv     = REGS_EN & REGS_RW;
  assign BUS_DRV = |drv;
  assign A_OUT   = regs[0];
  assign B_OUT   = regs[1];

  // Scan high to low so the lowest-index driver wins.
  always_comb begin
    BUS_OUT = '0;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (drv[i]) BUS_OUT = regs[i];
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      reg_wr[i]  = 1'b0;
      reg_nxt[i] = regs[i];
      if (REGS_INC[i] && !REGS_RW[i]) begin
        reg_wr[i]  = 1'b1;
        reg_nxt[i] = regs[i] + 1'b1;
      end else if (!REGS_INC[i] && REGS_EN[i] && !REGS_RW[i]) begin
        reg_wr[i]  = 1'b1;
        reg_nxt[i] = BUS_IN;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (reg_wr[i]) regs[i] <= reg_nxt[i];
      end
    end
  end

  logic [DATA_W-1:0] fifo_mem [OUT_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] last_head;
  logic              push;
  logic              push_ok;
  logic              pop;
  logic              empty;
  logic              full;
  logic              ovf_q;

  assign push    = reg_wr[OUT_IDX];
  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign pop     = !empty && OUT_READY;
  // A pop in the same cycle frees the slot the push needs.
  assign push_ok = push && (!full || pop);

  always_ff @(posedge CLK) begin
    if (RST && push_ok) fifo_mem[wr_ptr] <= reg_nxt[OUT_IDX];
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      last_head <= '0;
      ovf_q     <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        last_head <= fifo_mem[rd_ptr];
      end
      if (push_ok && !pop)      count <= count + 1'b1;
      else if (!push_ok && pop) count <= count - 1'b1;
      if (push && !push_ok) ovf_q <= 1'b1;
    end
  end

  assign OUT_VALID = !empty;
  assign OUT_DATA  = empty ? last_head : fifo_mem[rd_ptr];
  assign OUT_OVF   = ovf_q;

`ifdef BAT_REGFILE_BUS_CHECK_EN
  logic multi_drv;
  logic conflict_q;

  // Clearing the lowest set bit leaves something only when two or more regs drive.
  assign multi_drv = |(drv & (drv - 1'b1));

  always_ff @(posedge CLK) begin
    if (!RST)           conflict_q <= 1'b0;
    else if (multi_drv) conflict_q <= 1'b1;
  end

`ifndef SYNTHESIS
  always_ff @(posedge CLK) begin
    if (RST && multi_drv) $display("REGFILE bus conflict");
  end
`endif

  assign BUS_CONFLICT = conflict_q;
`else
  assign BUS_CONFLICT = 1'b0;
`endif

endmodule

// File: tb/tb_bat_register_file.sv
// Bench for bat_register_file: directed scenarios plus random traffic against an array/queue reference model.
module tb_bat_register_file;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] REGS_INC = 8'h00;
  logic [7:0] REGS_RW  = 8'hFF;
  logic [7:0] REGS_EN  = 8'h00;
  logic [7:0] BUS_IN   = 8'h00;
  logic       OUT_READY = 1'b0;
  logic [7:0] BUS_OUT, A_OUT, B_OUT, OUT_DATA;
  logic       BUS_DRV, OUT_VALID, OUT_OVF, BUS_CONFLICT;

  bat_register_file #(.DATA_W(8), .NUM_REGS(8), .OUT_DEPTH(4)) dut (
    .CLK(CLK), .RST(RST), .REGS_INC(REGS_INC), .REGS_RW(REGS_RW), .REGS_EN(REGS_EN),
    .BUS_IN(BUS_IN), .BUS_OUT(BUS_OUT), .BUS_DRV(BUS_DRV), .A_OUT(A_OUT), .B_OUT(B_OUT),
    .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_OVF(OUT_OVF),
    .BUS_CONFLICT(BUS_CONFLICT)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_fail = 0;

  int m_reg [8];
  int m_q [$];
  bit m_ovf;
  bit m_conf;
`ifdef BAT_REGFILE_BUS_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive inputs, then at the falling edge compare every output with the model.
  task automatic drive(input bit rst, input logic [7:0] inc, input logic [7:0] rw,
                       input logic [7:0] en, input logic [7:0] bus, input bit rdy);
    int drivers;
    int exp_bus;
    RST = rst; REGS_INC = inc; REGS_RW = rw; REGS_EN = en; BUS_IN = bus; OUT_READY = rdy;
    @(negedge CLK);
    drivers = 0;
    exp_bus = 0;
    for (int i = 7; i >= 0; i--) begin
      if (en[i] && rw[i]) begin
        drivers++;
        exp_bus = m_reg[i];
      end
    end
    check("bus_drv", BUS_DRV, drivers > 0);
    check("bus_out", BUS_OUT, exp_bus);
    check("a_out", A_OUT, m_reg[0]);
    check("b_out", B_OUT, m_reg[1]);
    check("out_valid", OUT_VALID, m_q.size() > 0);
    if (m_q.size() > 0) check("out_data", OUT_DATA, m_q[0]);
    check("out_ovf", OUT_OVF, m_ovf);
    check("bus_conflict", BUS_CONFLICT, m_conf);
  endtask

  task automatic tick();
    bit r7_written;
    int drivers;
    @(posedge CLK);
    if (!RST) begin
      for (int i = 0; i < 8; i++) m_reg[i] = 0;
      m_q.delete();
      m_ovf  = 0;
      m_conf = 0;
    end else begin
      drivers = 0;
      for (int i = 0; i < 8; i++) if (REGS_EN[i] && REGS_RW[i]) drivers++;
      if (CHECK_EN && drivers > 1) m_conf = 1;
      r7_written = 0;
      for (int i = 0; i < 8; i++) begin
        if (REGS_INC[i] && !REGS_RW[i]) begin
          m_reg[i] = (m_reg[i] + 1) % 256;
          if (i == 7) r7_written = 1;
        end else if (REGS_EN[i] && !REGS_RW[i]) begin
          m_reg[i] = BUS_IN;
          if (i == 7) r7_written = 1;
        end
      end
      if (OUT_READY && m_q.size() > 0) void'(m_q.pop_front());
      if (r7_written) begin
        if (m_q.size() < 4) m_q.push_back(m_reg[7]);
        else m_ovf = 1;
      end
    end
    #1;
  endtask

  task automatic step(input bit rst, input logic [7:0] inc, input logic [7:0] rw,
                      input logic [7:0] en, input logic [7:0] bus, input bit rdy);
    drive(rst, inc, rw, en, bus, rdy);
    tick();
  endtask

  initial begin
    logic [7:0] v;
    step(0, 8'h00, 8'hFF, 8'h00, 8'h00, 0);
    drive(1, 8'h00, 8'hFF, 8'h00, 8'h00, 0);
    check("rst_valid", OUT_VALID, 0);
    check("rst_ovf", OUT_OVF, 0);
    check("rst_a", A_OUT, 0);
    tick();

    // Load r2 and read it back onto the bus
    step(1, 8'h00, 8'hFB, 8'h04, 8'h5A, 0);
    drive(1, 8'h00, 8'hFF, 8'h04, 8'h00, 0);
    check("r2_read", BUS_OUT, 8'h5A);
    check("r2_drv", BUS_DRV, 1);
    tick();

    // r3 wraps FF->00, then INC with RW=1 is a no-op
    step(1, 8'h00, 8'hF7, 8'h08, 8'hFF, 0);
    step(1, 8'h08, 8'hF7, 8'h00, 8'h00, 0);
    drive(1, 8'h00, 8'hFF, 8'h08, 8'h00, 0);
    check("r3_wrap", BUS_OUT, 8'h00);
    tick();
    step(1, 8'h08, 8'hFF, 8'h08, 8'h33, 0);
    drive(1, 8'h00, 8'hFF, 8'h08, 8'h00, 0);
    check("r3_inc_rw_hold", BUS_OUT, 8'h00);
    tick();

    // MOV r2 -> r3; bench closes the bus loop itself
    drive(1, 8'h00, 8'hF7, 8'h0C, 8'h5A, 0);
    check("mov_src", BUS_OUT, 8'h5A);
    tick();
    drive(1, 8'h00, 8'hFF, 8'h08, 8'h00, 0);
    check("mov_dst", BUS_OUT, 8'h5A);
    check("mov_a", A_OUT, 8'h00);
    tick();

    // Overflow: five r7 writes into a 4-deep FIFO with no consumer
    for (int k = 1; k <= 5; k++) step(1, 8'h00, 8'h7F, 8'h80, 8'(k), 0);
    drive(1, 8'h00, 8'hFF, 8'h00, 8'h00, 0);
    check("ovf_set", OUT_OVF, 1);
    check("ovf_head", OUT_DATA, 8'h01);
    tick();
    for (int k = 1; k <= 4; k++) begin
      drive(1, 8'h00, 8'hFF, 8'h00, 8'h00, 1);
      check("drain_data", OUT_DATA, 8'(k));
      check("drain_valid", OUT_VALID, 1);
      tick();
    end
    drive(1, 8'h00, 8'hFF, 8'h00, 8'h00, 1);
    check("drained", OUT_VALID, 0);
    check("ovf_sticky", OUT_OVF, 1);
    tick();

    // Full FIFO with simultaneous push and pop
    step(0, 8'h00, 8'hFF, 8'h00, 8'h00, 0);
    for (int k = 1; k <= 4; k++) step(1, 8'h00, 8'h7F, 8'h80, 8'(k), 0);
    step(1, 8'h80, 8'h7F, 8'h00, 8'h00, 1);
    drive(1, 8'h00, 8'hFF, 8'h00, 8'h00, 0);
    check("fullpp_ovf", OUT_OVF, 0);
    check("fullpp_head", OUT_DATA, 8'h02);
    tick();
    for (int k = 2; k <= 5; k++) begin
      drive(1, 8'h00, 8'hFF, 8'h00, 8'h00, 1);
      check("fullpp_data", OUT_DATA, 8'(k));
      tick();
    end

    // Mid-stream reset with entries queued and a push/pop pending
    for (int k = 1; k <= 3; k++) step(1, 8'h00, 8'h7E, 8'h81, 8'(8'h10 + k), 0);
    step(0, 8'h80, 8'h7F, 8'h00, 8'h00, 1);
    drive(1, 8'h00, 8'hFF, 8'h00, 8'h00, 0);
    check("midrst_valid", OUT_VALID, 0);
    check("midrst_ovf", OUT_OVF, 0);
    check("midrst_a", A_OUT, 0);
    tick();

    // Two drivers: lowest index wins
    step(1, 8'h00, 8'hFC, 8'h03, 8'hA7, 0);
    drive(1, 8'h00, 8'hFF, 8'h01, 8'h00, 0);
    tick();
    step(1, 8'h00, 8'hFD, 8'h02, 8'h3C, 0);
    drive(1, 8'h00, 8'hFF, 8'h03, 8'h00, 0);
    check("multi_lowest", BUS_OUT, 8'hA7);
    tick();
    drive(1, 8'h00, 8'hFF, 8'h00, 8'h00, 0);
    check("conflict", BUS_CONFLICT, CHECK_EN);
    tick();
    step(1, 8'h00, 8'hFF, 8'h00, 8'h00, 0);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      v = 8'($urandom);
      step(($urandom_range(0, 99) != 0), 8'($urandom & $urandom), 8'($urandom),
           v, 8'($urandom), 1'($urandom_range(0, 2) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
